// File: rtl/tape_pkg.sv
// ---------------------------------------------------------------------------
// tape_pkg
// Shared definitions for the tape line scheduler slice.
//   - state_t : scheduler state encoding
//   - *_DEF   : default values for the scheduler parameters
// No ports (package).
// ---------------------------------------------------------------------------
package tape_pkg;

   // Scheduler states, in the order a committed line walks through them
   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      COMMIT,
      STREAM,
      DRAIN
   } state_t;

   // Default parameter values shared by the top and the bench
   localparam int LINE_BYTES_DEF = 331;
   localparam int DEPTH_DEF      = 1024;
   localparam int FILL_BYTE_DEF  = 41;
   localparam int CLAMP_LO_DEF   = 43;
   localparam int CLAMP_HI_DEF   = 179;

endpackage

// File: rtl/tape_byte_fifo.sv
// ---------------------------------------------------------------------------
// tape_byte_fifo
// Synchronous first-word-fall-through byte FIFO. The head byte is always
// visible on o_head; o_headNext shows the entry behind it so the owner can
// preload a registered output on the same edge that pops.
//
// Ports:
//   i_clk       clock
//   i_rst       asynchronous active-high reset (pointers and level cleared)
//   i_push      write request; ignored while full, even if popping
//   i_data      byte to write
//   i_pop       read request; ignored while empty
//   o_full      FIFO holds DEPTH bytes
//   o_empty     FIFO holds no bytes
//   o_level     occupancy, 0..DEPTH
//   o_head      byte at the read pointer
//   o_headNext  byte one behind the read pointer
// ---------------------------------------------------------------------------
module tape_byte_fifo
   import tape_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [7:0]               i_data,
   input  logic                     i_pop,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [7:0]               o_head,
   output logic [7:0]               o_headNext
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [LW-1:0] r_level;
   logic          w_full;
   logic          w_empty;
   logic          w_pushOk;
   logic          w_popOk;

   // A full FIFO refuses writes outright; a simultaneous pop does not
   // make room for the byte offered in the same cycle.
   assign w_full   = (r_level == FULL_LVL);
   assign w_empty  = (r_level == '0);
   assign w_pushOk = i_push && !w_full;
   assign w_popOk  = i_pop && !w_empty;

   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_level    = r_level;
   assign o_head     = r_mem[r_rdPtr];
   assign o_headNext = r_mem[r_rdPtr + PTR_ONE];

   // Storage array is not reset; only the pointers define what is valid
   always_ff @(posedge i_clk) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop together keeps the level
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_popOk) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         case ({w_pushOk, w_popOk})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/tape_line_scheduler.sv
// ---------------------------------------------------------------------------
// tape_line_scheduler
// Buffers tape-formatter bytes and hands the composite video encoder exactly
// one full line of payload per committed line. A line is advertised only
// once LINE_BYTES bytes are queued, committed on the encoder's start-of-line
// strobe, and streamed during the active window. Every other byte the
// encoder takes is FILL_BYTE.
//
// Optional feature macro: TAPE_SCHED_CLAMP_EN
//   defined   - payload bytes are clamped to [CLAMP_LO, CLAMP_HI]
//   undefined - payload bytes pass through unchanged
//
// Ports:
//   clkin       system clock
//   rst         asynchronous active-high reset
//   src_valid   upstream byte valid
//   src_data    upstream byte
//   src_ready   FIFO can accept (not full)
//   line_valid  a full line is armed or committed
//   vid_sol     encoder start-of-line pulse
//   vid_ready   encoder consumes data_out this cycle
//   data_out    byte presented to the encoder (registered)
//   lines_sent  completed committed lines, wraps at 16 bits
//   short_line  sticky: a committed line was cut short by the encoder
//   fifo_level  current FIFO occupancy
// ---------------------------------------------------------------------------
module tape_line_scheduler
   import tape_pkg::*;
#(
   parameter int LINE_BYTES = LINE_BYTES_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int FILL_BYTE  = FILL_BYTE_DEF,
   parameter int CLAMP_LO   = CLAMP_LO_DEF,
   parameter int CLAMP_HI   = CLAMP_HI_DEF
) (
   input  logic                     clkin,
   input  logic                     rst,
   input  logic                     src_valid,
   input  logic [7:0]               src_data,
   output logic                     src_ready,
   output logic                     line_valid,
   input  logic                     vid_sol,
   input  logic                     vid_ready,
   output logic [7:0]               data_out,
   output logic [15:0]              lines_sent,
   output logic                     short_line,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(LINE_BYTES + 1);
   localparam logic [LW-1:0] LINE_LVL = LW'(LINE_BYTES);
   localparam logic [CW-1:0] LINE_CNT = CW'(LINE_BYTES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [7:0]    FILL     = 8'(FILL_BYTE);

   // Reject parameter sets the FIFO and clamp logic cannot honour
   if (DEPTH < LINE_BYTES || DEPTH < 2 || (1 << $clog2(DEPTH)) != DEPTH ||
       CLAMP_LO > CLAMP_HI) begin : g_badParams
      $error("tape_line_scheduler: invalid parameter set");
   end

   state_t        r_state;
   state_t        w_stateNext;
   logic [CW-1:0] r_byteCount;
   logic [CW-1:0] w_countNext;
   logic [CW-1:0] w_countPlus;
   logic [7:0]    r_dataOut;
   logic [15:0]   r_linesSent;
   logic          r_shortLine;
   logic          w_shortSet;
   logic          w_lineDone;
   logic          w_pop;
   logic          w_fifoFull;
   logic          w_fifoEmpty;
   logic [LW-1:0] w_level;
   logic [7:0]    w_head;
   logic [7:0]    w_headNext;
   logic [7:0]    w_nextHead;

   // Payload shaping applied to every byte taken from the FIFO
   function automatic logic [7:0] clampByte(input logic [7:0] b);
`ifdef TAPE_SCHED_CLAMP_EN
      if (b < 8'(CLAMP_LO)) begin
         return 8'(CLAMP_LO);
      end else if (b > 8'(CLAMP_HI)) begin
         return 8'(CLAMP_HI);
      end else begin
         return b;
      end
`else
      return b;
`endif
   endfunction

   tape_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk      (clkin),
      .i_rst      (rst),
      .i_push     (src_valid),
      .i_data     (src_data),
      .i_pop      (w_pop),
      .o_full     (w_fifoFull),
      .o_empty    (w_fifoEmpty),
      .o_level    (w_level),
      .o_head     (w_head),
      .o_headNext (w_headNext)
   );

   // Bytes are consumed only inside a committed line; the first consumed
   // byte of a line is taken in COMMIT itself so the encoder gets exactly
   // one payload byte per vid_ready cycle from the start of the window.
   assign w_pop       = vid_ready && !w_fifoEmpty &&
                        (r_state == COMMIT || r_state == STREAM);
   assign w_countPlus = r_byteCount + CNT_ONE;
   assign w_nextHead  = w_pop ? w_headNext : w_head;

   // Next-state logic for the line handshake. IDLE ignores vid_sol, so a
   // strobe that coincides with reaching the threshold does not commit.
   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_byteCount;
      w_shortSet  = 1'b0;
      w_lineDone  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_level >= LINE_LVL) begin
               w_stateNext = ARMED;
            end
         end
         ARMED: begin
            if (vid_sol) begin
               w_stateNext = COMMIT;
            end
         end
         COMMIT, STREAM: begin
            if (w_pop) begin
               w_countNext = w_countPlus;
               w_stateNext = (w_countPlus == LINE_CNT) ? DRAIN : STREAM;
            end else if (r_state == STREAM) begin
               w_shortSet  = 1'b1;
               w_countNext = '0;
               w_stateNext = IDLE;
            end
         end
         DRAIN: begin
            if (!vid_ready) begin
               w_lineDone  = 1'b1;
               w_countNext = '0;
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_countNext = '0;
         end
      endcase
   end

   // State, byte counter and line statistics
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_byteCount <= '0;
         r_linesSent <= '0;
         r_shortLine <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_byteCount <= w_countNext;
         if (w_lineDone) begin
            r_linesSent <= r_linesSent + 16'd1;
         end
         if (w_shortSet) begin
            r_shortLine <= 1'b1;
         end
      end
   end

   // Registered output byte: preload what the encoder should see next
   // cycle, i.e. the post-pop FIFO head while a line is being fed, fill
   // otherwise. This keeps the read zero-latency from the encoder's view.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_dataOut <= FILL;
      end else if (w_stateNext == COMMIT || w_stateNext == STREAM) begin
         r_dataOut <= clampByte(w_nextHead);
      end else begin
         r_dataOut <= FILL;
      end
   end

   assign src_ready  = !w_fifoFull;
   assign line_valid = (r_state == ARMED) || (r_state == COMMIT);
   assign data_out   = r_dataOut;
   assign lines_sent = r_linesSent;
   assign short_line = r_shortLine;
   assign fifo_level = w_level;

endmodule

// File: tb/tb_tape_line_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tape_line_scheduler
// Self-checking bench for tape_line_scheduler with default parameters.
// Pushed payload bytes go into a scoreboard queue (after the bench's own
// clamp model) and are popped and compared as the encoder consumes them.
// ---------------------------------------------------------------------------
module tb_tape_line_scheduler;

   localparam int LINE  = 331;
   localparam int DEPTH = 1024;
   localparam int FILL  = 41;

   logic        clkin = 1'b0;
   logic        rst = 1'b1;
   logic        src_valid = 1'b0;
   logic [7:0]  src_data = 8'd0;
   logic        src_ready;
   logic        line_valid;
   logic        vid_sol = 1'b0;
   logic        vid_ready = 1'b0;
   logic [7:0]  data_out;
   logic [15:0] lines_sent;
   logic        short_line;
   logic [10:0] fifo_level;

   int total = 0;
   int bad = 0;
   int expLines = 0;
   logic [7:0] sb[$];

   typedef struct {
      string      name;
      logic [7:0] inByte;
      logic [7:0] expOut;
   } vec_t;
   vec_t vecs[5];

   tape_line_scheduler #(
      .LINE_BYTES (LINE),
      .DEPTH      (DEPTH)
   ) dut (
      .clkin      (clkin),
      .rst        (rst),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .line_valid (line_valid),
      .vid_sol    (vid_sol),
      .vid_ready  (vid_ready),
      .data_out   (data_out),
      .lines_sent (lines_sent),
      .short_line (short_line),
      .fifo_level (fifo_level)
   );

   // Free-running clock
   always #5 clkin = ~clkin;

   // Hard stop in case a sequence never reaches its summary
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference payload shaping
   function automatic logic [7:0] modelClamp(input logic [7:0] b);
`ifdef TAPE_SCHED_CLAMP_EN
      if (b < 8'd43) return 8'd43;
      if (b > 8'd179) return 8'd179;
      return b;
`else
      return b;
`endif
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      src_valid = 1'b0;
      vid_sol = 1'b0;
      vid_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      sb.delete();
      expLines = 0;
   endtask

   // Offer one byte until accepted; accepted bytes feed the scoreboard
   task automatic applyStimulus(input logic [7:0] b, input bit toSb);
      bit done = 1'b0;
      src_valid = 1'b1;
      src_data = b;
      for (int k = 0; k < 64 && !done; k++) begin
         done = src_ready;
         tick();
      end
      src_valid = 1'b0;
      if (!done) checkOutput("push accepted", 0, 1);
      else if (toSb) sb.push_back(modelClamp(b));
   endtask

   task automatic waitArmed(input string tag);
      for (int k = 0; k < 8 && !line_valid; k++) tick();
      checkOutput({tag, " armed line_valid"}, int'(line_valid), 1);
   endtask

   task automatic commitLine(input string tag);
      vid_sol = 1'b1;
      tick();
      vid_sol = 1'b0;
      checkOutput({tag, " committed line_valid"}, int'(line_valid), 1);
   endtask

   task automatic streamBytes(input string tag, input int n);
      logic [7:0] exp;
      vid_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (sb.size() == 0) begin
            checkOutput({tag, " scoreboard underflow"}, 0, 1);
         end else begin
            exp = sb.pop_front();
            checkOutput($sformatf("%s data[%0d]", tag, i), int'(data_out), int'(exp));
         end
         tick();
      end
   endtask

   task automatic streamFill(input string tag, input int n);
      vid_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s fill[%0d]", tag, i), int'(data_out), FILL);
         tick();
      end
   endtask

   task automatic endLine();
      vid_ready = 1'b0;
      tick();
   endtask

   task automatic setVec(input int idx, input string name, input logic [7:0] inB,
                         input logic [7:0] expB);
      vecs[idx].name = name;
      vecs[idx].inByte = inB;
      vecs[idx].expOut = expB;
   endtask

   initial begin
      int n;
      bit acc;

      setVec(0, "clamp in=0",   8'd0,   8'd0);
      setVec(1, "clamp in=42",  8'd42,  8'd42);
      setVec(2, "clamp in=100", 8'd100, 8'd100);
      setVec(3, "clamp in=200", 8'd200, 8'd200);
      setVec(4, "clamp in=255", 8'd255, 8'd255);
`ifdef TAPE_SCHED_CLAMP_EN
      vecs[0].expOut = 8'd43;
      vecs[1].expOut = 8'd43;
      vecs[3].expOut = 8'd179;
      vecs[4].expOut = 8'd179;
`endif

      // Reset state
      applyReset();
      checkOutput("reset fifo_level", int'(fifo_level), 0);
      checkOutput("reset src_ready", int'(src_ready), 1);
      checkOutput("reset line_valid", int'(line_valid), 0);
      checkOutput("reset data_out", int'(data_out), FILL);
      checkOutput("reset lines_sent", int'(lines_sent), 0);
      checkOutput("reset short_line", int'(short_line), 0);

      // One byte short of a line: never armed, encoder sees only fill
      for (int i = 0; i < LINE - 1; i++) applyStimulus(8'(i), 1'b1);
      tick();
      checkOutput("partial level", int'(fifo_level), LINE - 1);
      vid_sol = 1'b1;
      vid_ready = 1'b1;
      for (int i = 0; i < LINE; i++) begin
         checkOutput($sformatf("partial fill[%0d]", i), int'(data_out), FILL);
         checkOutput($sformatf("partial line_valid[%0d]", i), int'(line_valid), 0);
         tick();
         vid_sol = 1'b0;
      end
      endLine();
      checkOutput("partial level after", int'(fifo_level), LINE - 1);
      checkOutput("partial lines_sent", int'(lines_sent), 0);

      // Exact line of wrapping bytes, then one trailing fill byte
      applyReset();
      for (int i = 0; i < LINE; i++) applyStimulus(8'(i & 255), 1'b1);
      waitArmed("exact");
      checkOutput("exact armed level", int'(fifo_level), LINE);
      commitLine("exact");
      streamBytes("exact", LINE);
      streamFill("exact", 1);
      endLine();
      expLines++;
      checkOutput("exact lines_sent", int'(lines_sent), expLines);
      checkOutput("exact level", int'(fifo_level), 0);
      checkOutput("exact short_line", int'(short_line), 0);
      checkOutput("exact line_valid", int'(line_valid), 0);

      // Encoder drops the window after 200 bytes
      for (int i = 0; i < LINE; i++) applyStimulus(8'((i * 7 + 3) & 255), 1'b1);
      waitArmed("short");
      commitLine("short");
      streamBytes("short", 200);
      endLine();
      checkOutput("short short_line", int'(short_line), 1);
      checkOutput("short level", int'(fifo_level), LINE - 200);
      checkOutput("short lines_sent", int'(lines_sent), expLines);
      checkOutput("short line_valid", int'(line_valid), 0);
      checkOutput("short data_out", int'(data_out), FILL);

      // Leftover bytes lead the next line; short_line stays sticky
      for (int i = 0; i < 200; i++) applyStimulus(8'((i * 5) & 255), 1'b1);
      waitArmed("resume");
      commitLine("resume");
      streamBytes("resume", LINE);
      streamFill("resume", 1);
      endLine();
      expLines++;
      checkOutput("resume lines_sent", int'(lines_sent), expLines);
      checkOutput("resume short_line", int'(short_line), 1);
      checkOutput("resume level", int'(fifo_level), 0);

      // Clamp vectors lead a line; the rest goes through the scoreboard
      for (int v = 0; v < 5; v++) applyStimulus(vecs[v].inByte, 1'b0);
      for (int i = 0; i < LINE - 5; i++) applyStimulus(8'((i + 17) & 255), 1'b1);
      waitArmed("clamp");
      commitLine("clamp");
      vid_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         checkOutput(vecs[v].name, int'(data_out), int'(vecs[v].expOut));
         tick();
      end
      streamBytes("clamp", LINE - 5);
      streamFill("clamp", 1);
      endLine();
      expLines++;
      checkOutput("clamp lines_sent", int'(lines_sent), expLines);

      // Reset in the middle of a streamed line
      for (int i = 0; i < LINE; i++) applyStimulus(8'(255 - (i & 255)), 1'b1);
      waitArmed("midreset");
      commitLine("midreset");
      streamBytes("midreset", 100);
      rst = 1'b1;
      tick();
      checkOutput("midreset level", int'(fifo_level), 0);
      checkOutput("midreset line_valid", int'(line_valid), 0);
      checkOutput("midreset data_out", int'(data_out), FILL);
      checkOutput("midreset lines_sent", int'(lines_sent), 0);
      checkOutput("midreset short_line", int'(short_line), 0);
      checkOutput("midreset src_ready", int'(src_ready), 1);
      vid_ready = 1'b0;
      rst = 1'b0;
      tick();

      // Fill to capacity with no reads, then pop while still offering a byte
      applyReset();
      n = 0;
      src_valid = 1'b1;
      src_data = 8'hA5;
      for (int c = 0; c < 1100; c++) begin
         acc = src_ready;
         tick();
         if (acc) n++;
         if (!src_ready) break;
      end
      checkOutput("full accepted count", n, DEPTH);
      checkOutput("full src_ready", int'(src_ready), 0);
      checkOutput("full level", int'(fifo_level), DEPTH);
      tick();
      checkOutput("full level held", int'(fifo_level), DEPTH);
      vid_sol = 1'b1;
      tick();
      vid_sol = 1'b0;
      vid_ready = 1'b1;
      tick();
      checkOutput("full push+pop level", int'(fifo_level), DEPTH - 1);
      checkOutput("full push+pop src_ready", int'(src_ready), 1);
      vid_ready = 1'b0;
      src_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
